uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Buffered UART transmitter: accepts bytes from the sort FSM or host logic into a FIFO and serializes them as 8N1 frames on o_Tx_Serial. It is the sending end matching uart_rx, and returns sorted results to the link partner without the producer pacing itself to the baud rate. Frames are sent back-to-back while the FIFO holds data.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz / 115200); legal >= 2
FIFO_DEPTH, 8, byte entries; power of two, >= 2

Ports:
i_Clock  in  1  system clock; all logic on rising edge
i_Reset  in  1  synchronous, active-high reset
i_Wr_DV  in  1  write strobe; i_Wr_Byte sampled when high
i_Wr_Byte  in  8  byte to queue
o_Full  out  1  count == FIFO_DEPTH
o_Empty  out  1  count == 0
o_Count  out  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the frame in flight
o_Overflow  out  1  1-cycle pulse: write dropped because FIFO full
o_Tx_Serial  out  1  UART line; idle high
o_Tx_Active  out  1  high from start bit through end of stop bit
o_Tx_Done  out  1  1-cycle pulse on the last cycle of each stop bit

Behaviour:
- One clock; reset is synchronous and active-high. Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Count=0, o_Empty=1, o_Full=0. FIFO pointers are cleared and state=IDLE.
- Write: accepted at an edge when i_Wr_DV=1 and count<FIFO_DEPTH. The full check uses the pre-edge count; a write while full is dropped even if a pop occurs at the same edge. A dropped write raises o_Overflow for exactly that next cycle.
- Count update: count_next = count + accepted_write - pop. Pointers wrap modulo FIFO_DEPTH. o_Full, o_Empty, and o_Count are registered and consistent with count.
- FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLKS_PER_BIT-1. An index counter counts 0..7.
- IDLE: o_Tx_Serial=1 and o_Tx_Active=0. If count>0, pop the head into the shift register, go to START, and drive o_Tx_Serial=0 and o_Tx_Active=1.
- START: line held 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: bits sent LSB first. Each bit is held for CLKS_PER_BIT cycles. After bit 7, go to STOP.
- STOP: line held 1 for CLKS_PER_BIT cycles. o_Tx_Done pulses on the final cycle. At that final edge:
  - if count>0, pop and enter START directly (no idle cycle between frames);
  - otherwise go to IDLE and drop o_Tx_Active.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency: a write accepted at edge E into an empty idle block gives o_Tx_Serial=0 after edge E+1.
- Write to empty FIFO on the final STOP cycle: the pop check sees count=0, so the FSM goes to IDLE. The next frame starts one cycle later, giving exactly one idle-high cycle.
- Writes are never blocked by transmission; the frame in flight is held in the shift register, not in the FIFO.
- Reset mid-frame: the line returns high after the reset edge, no o_Tx_Done is issued, FIFO contents are discarded, and the partial frame is abandoned.
- i_Wr_Byte is ignored when i_Wr_DV=0.

Test Plan:
- CLKS_PER_BIT=4. After reset, write 0xAB once -> line low 1 cycle after the write edge for 4 cycles. Data bits are 1,1,0,1,0,1,0,1 (4 cycles each), then the stop bit is high. Frame = 40 cycles, one o_Tx_Done pulse, o_Empty=1 throughout the frame.
- Write 0x3F, 0x00, 0xFF on 3 consecutive cycles -> three contiguous frames totalling 120 cycles with no idle gap. Three o_Tx_Done pulses. o_Tx_Active stays high for the whole burst. Received bytes are 0x3F, 0x00, 0xFF.
- FIFO_DEPTH=8; write 10 bytes on 10 consecutive cycles -> first byte is popped immediately and the next 8 are stored. o_Full=1 and o_Count=8 after the 9th write. The 10th write is dropped with a single o_Overflow pulse. Exactly 9 frames are sent, in order.
- Write one byte on the final STOP cycle of the previous frame with FIFO empty -> exactly one idle-high cycle, then the new frame is sent correctly.
- Assert i_Reset during data bit 3 of 0x55 with 2 bytes queued -> o_Tx_Serial=1, o_Count=0, and o_Tx_Active=0 the cycle after reset. No o_Tx_Done is issued. A subsequent write of 0xA5 transmits cleanly.
- Default parameters (87): write 0xC3 -> each bit lasts exactly 87 cycles and the frame lasts 870 cycles. A uart_rx instance on the line returns 0xC3.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART serializer.
// Ports:
//   i_Clock, i_Reset       clock and synchronous active-high reset
//   i_Wr_DV, i_Wr_Byte     write strobe and byte to queue
//   o_Full, o_Empty        FIFO occupancy flags
//   o_Count                bytes queued, excluding the frame in flight
//   o_Overflow             one-cycle pulse when a write is dropped (FIFO full)
//   o_Tx_Serial            UART line, idle high
//   o_Tx_Active            high from start bit through end of stop bit
//   o_Tx_Done              one-cycle pulse on the last cycle of each stop bit
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Wr_DV,
  input  logic [7:0]                   i_Wr_Byte,
  output logic                         o_Full,
  output logic                         o_Empty,
  output logic [$clog2(FIFO_DEPTH):0]  o_Count,
  output logic                         o_Overflow,
  output logic                         o_Tx_Serial,
  output logic                         o_Tx_Active,
  output logic                         o_Tx_Done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_PENULT = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          wr_ok;
  logic          pop;
  logic          bit_last;

  // Write acceptance and pop both use the pre-edge count; pop happens when
  // the serializer is free (idle, or finishing a stop bit).
  always_comb begin
    bit_last   = (bit_cnt == BIT_LAST);
    wr_ok      = i_Wr_DV && (count != DEPTH_C);
    pop        = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_last));
    count_next = count + CW'(wr_ok) - CW'(pop);
  end

  assign o_Count = count;

  // FIFO pointers, occupancy and flags.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      count      <= count_next;
      o_Full     <= (count_next == DEPTH_C);
      o_Empty    <= (count_next == '0);
      o_Overflow <= i_Wr_DV && !wr_ok;
    end
  end

  // Storage array; not reset, contents are qualified by count.
  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem[wr_ptr] <= i_Wr_Byte;
  end

  // Serializer: the byte in flight lives in shreg, shifted right per data bit.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt     <= '0;
          bit_idx     <= '0;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          if (pop) begin
            shreg       <= mem[rd_ptr];
            state       <= START;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
          end
        end
        START: begin
          if (bit_last) begin
            bit_cnt     <= '0;
            bit_idx     <= '0;
            state       <= DATA;
            o_Tx_Serial <= shreg[0];
            shreg       <= {1'b0, shreg[7:1]};
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state       <= STOP;
              o_Tx_Serial <= 1'b1;
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_Tx_Serial <= shreg[0];
              shreg       <= {1'b0, shreg[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_last) begin
            bit_cnt <= '0;
            if (pop) begin
              // Back-to-back frame: straight into the next start bit.
              shreg       <= mem[rd_ptr];
              state       <= START;
              o_Tx_Serial <= 1'b0;
            end else begin
              state       <= IDLE;
              o_Tx_Active <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
            // Registered pulse lands on the final stop cycle.
            if (bit_cnt == BIT_PENULT) o_Tx_Done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
